// File: rtl/amax10_qsys_sample_logger.sv
// -----------------------------------------------------------------------------
// amax10_qsys_sample_logger
//
// Logs a 32-bit sample stream into a downstream on-chip memory (circular
// buffer of DEPTH words), serves random-access readback of the logged words,
// and can scrub the whole memory to zero on request.
//
// Ports
//   clk, reset_n        single clock; asynchronous active-low reset
//   enable              level, 1 = accept samples (IDLE <-> RUN)
//   clear               single-cycle pulse, (re)starts a memory scrub
//   snk_valid/ready/data  sample sink
//   rd_req/addr/ack     readback request
//   rd_valid/data/err   readback response, three cycles after acceptance
//   mem_*               memory slave port (registered outputs, mem_clken
//                       follows reset_n)
//   wr_ptr, fill_count, wrapped, busy   status
//   fsm_state           current FSM state (0 IDLE, 1 RUN, 2 SCRUB)
//
// Handshakes: a transfer happens in a cycle where both sides are high at the
// rising clock edge (snk_valid & snk_ready, rd_req & rd_ack). Ready/ack are
// combinational and may depend on the partner's valid/req; valid/req never
// depend on ready/ack.
//
// DEPTH must be strictly below 2**ADDR_W so fill_count can hold DEPTH and
// out-of-range read addresses are representable.
// -----------------------------------------------------------------------------
module amax10_qsys_sample_logger #(
  parameter int DEPTH  = 25000,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              snk_valid,
  output logic              snk_ready,
  input  logic [31:0]       snk_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic              rd_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] fill_count,
  output logic              wrapped,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SCRUB = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] scrub_addr;

  logic              sample_fire;
  logic              read_fire;
  logic              read_in_range;
  logic              scrub_done;

  // Read response pipeline: stage 1 is the cycle the memory sees the
  // address, stage 2 the cycle mem_readdata is valid.
  logic              rd_p1_valid;
  logic              rd_p1_err;
  logic              rd_p2_valid;
  logic              rd_p2_err;

  // ---------------------------------------------------------------------------
  // Handshakes and status
  // ---------------------------------------------------------------------------
  // A pending read always blocks samples, so the memory port never sees a
  // read and a sample write in the same cycle.
  assign snk_ready = (state == RUN) & ~rd_req;
  // No reads during a scrub, nor in the cycle that starts one.
  assign rd_ack    = rd_req & (state != SCRUB) & ~clear;

  assign sample_fire   = snk_valid & snk_ready;
  assign read_fire     = rd_req & rd_ack;
  assign read_in_range = {1'b0, rd_addr} < DEPTH_EXT;
  assign scrub_done    = (state == SCRUB) & ~clear & (scrub_addr == LAST_ADDR);

  assign busy      = (state == SCRUB);
  assign fsm_state = state;

  // Clock enable tracks reset directly so the memory is enabled in the very
  // first cycle after reset release, not one cycle later.
  assign mem_clken = reset_n;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = SCRUB;
    end else begin
      unique case (state)
        IDLE:    if (enable)  state_next = RUN;
        RUN:     if (!enable) state_next = IDLE;
        SCRUB: begin
          if (scrub_addr == LAST_ADDR) begin
            state_next = enable ? RUN : IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Scrub address counter. A clear (from any state) restarts it at 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scrub_addr <= '0;
    end else if (clear) begin
      scrub_addr <= '0;
    end else if (state == SCRUB) begin
      scrub_addr <= (scrub_addr == LAST_ADDR) ? '0 : scrub_addr + ADDR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Write pointer, fill level and wrap flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      fill_count <= '0;
      wrapped    <= 1'b0;
    end else if (scrub_done) begin
      wr_ptr     <= '0;
      fill_count <= '0;
      wrapped    <= 1'b0;
    end else if (sample_fire) begin
      if (wr_ptr == LAST_ADDR) begin
        wr_ptr  <= '0;
        wrapped <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if ({1'b0, fill_count} != DEPTH_EXT) begin
        fill_count <= fill_count + ADDR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory command register. Scrub, read and sample never compete for the
  // port: reads and samples are only accepted outside SCRUB, and a read
  // blocks samples. The clear cycle itself issues no scrub write so the first
  // scrub write after a restart is always address 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_byteenable <= 4'h0;
      mem_address    <= '0;
      mem_writedata  <= '0;
    end else begin
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_byteenable <= 4'h0;
      mem_address    <= '0;
      mem_writedata  <= '0;
      if (state == SCRUB) begin
        if (!clear) begin
          mem_chipselect <= 1'b1;
          mem_write      <= 1'b1;
          mem_byteenable <= 4'hF;
          mem_address    <= scrub_addr;
          mem_writedata  <= 32'h0;
        end
      end else if (read_fire) begin
        // Out-of-range reads never touch the memory.
        if (read_in_range) begin
          mem_chipselect <= 1'b1;
          mem_byteenable <= 4'hF;
          mem_address    <= rd_addr;
        end
      end else if (sample_fire) begin
        mem_chipselect <= 1'b1;
        mem_write      <= 1'b1;
        mem_byteenable <= 4'hF;
        mem_address    <= wr_ptr;
        mem_writedata  <= snk_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read response pipeline. Accepted in N, address on the port in N+1,
  // memory data valid in N+2 and captured at its end, response in N+3.
  // Reset clears every stage, so in-flight reads are dropped silently.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_p1_valid <= 1'b0;
      rd_p1_err   <= 1'b0;
      rd_p2_valid <= 1'b0;
      rd_p2_err   <= 1'b0;
      rd_valid    <= 1'b0;
      rd_err      <= 1'b0;
      rd_data     <= 32'h0;
    end else begin
      rd_p1_valid <= read_fire;
      rd_p1_err   <= read_fire & ~read_in_range;
      rd_p2_valid <= rd_p1_valid;
      rd_p2_err   <= rd_p1_err;
      rd_valid    <= rd_p2_valid;
      rd_err      <= rd_p2_valid & rd_p2_err;
      if (rd_p2_valid && !rd_p2_err) begin
        rd_data <= mem_readdata;
      end else begin
        rd_data <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_amax10_qsys_sample_logger.sv
// -----------------------------------------------------------------------------
// tb_amax10_qsys_sample_logger
//
// Directed bench for amax10_qsys_sample_logger with a behavioural model of the
// downstream memory (one-cycle read latency). Read responses are checked
// against an expected queue; scrub writes against an expected address
// counter; everything else against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_amax10_qsys_sample_logger;

  localparam int DEPTH  = 25000;
  localparam int ADDR_W = 15;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_SCRUB = 2'd2;

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic              clear;
  logic              snk_valid;
  logic              snk_ready;
  logic [31:0]       snk_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [31:0]       rd_data;
  logic              rd_err;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic [31:0]       mem_readdata = 32'h0;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] fill_count;
  logic              wrapped;
  logic              busy;
  logic [1:0]        fsm_state;

  amax10_qsys_sample_logger #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .clear          (clear),
    .snk_valid      (snk_valid),
    .snk_ready      (snk_ready),
    .snk_data       (snk_data),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_ack         (rd_ack),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .rd_err         (rd_err),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .wr_ptr         (wr_ptr),
    .fill_count     (fill_count),
    .wrapped        (wrapped),
    .busy           (busy),
    .fsm_state      (fsm_state)
  );

  // ---------------------------------------------------------------------------
  // Clock, cycle counter, memory model
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem_model [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) mem_model[mem_address] <= mem_writedata;
      else           mem_readdata <= mem_model[mem_address];
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          exp_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Read responses: data, error flag and exact cycle of arrival.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: got rd_valid=1, expected no response (t=%0t)", $time);
      end else begin
        logic [31:0] e_data;
        logic        e_err;
        int          e_cyc;
        e_data = exp_q.pop_front();
        e_err  = exp_err_q.pop_front();
        e_cyc  = exp_cyc_q.pop_front();
        check("rd_data", rd_data, e_data);
        check("rd_err", 32'(rd_err), 32'(e_err));
        check("rd_latency", 32'(cyc), 32'(e_cyc));
      end
    end
  end

  // Scrub writes: zeros to strictly ascending addresses.
  logic scrub_watch    = 1'b0;
  int   scrub_exp_addr = 0;
  always @(negedge clk) begin
    if (scrub_watch && mem_chipselect && mem_write) begin
      check("scrub_addr", 32'(mem_address), 32'(scrub_exp_addr));
      check("scrub_data", mem_writedata, 32'h0);
      scrub_exp_addr++;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge+1, return at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic push_read(input logic [31:0] data, input logic err);
    exp_q.push_back(data);
    exp_err_q.push_back(err);
    exp_cyc_q.push_back(cyc + 3);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                         input logic err);
    rd_req  = 1'b1;
    rd_addr = addr;
    #1;
    check("rd_ack", 32'(rd_ack), 32'd1);
    check("snk_ready_vs_read", 32'(snk_ready), 32'd0);
    push_read(data, err);
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    check("rd_cmd_cs", 32'(mem_chipselect), 32'(!err));
    check("rd_cmd_we", 32'(mem_write), 32'd0);
    if (!err) check("rd_cmd_addr", 32'(mem_address), 32'(addr));
  endtask

  task automatic send_sample(input logic [31:0] data, input int exp_addr);
    snk_valid = 1'b1;
    snk_data  = data;
    #1;
    check("snk_ready", 32'(snk_ready), 32'd1);
    @(posedge clk);
    #1;
    snk_valid = 1'b0;
    check("wr_cmd_cs", 32'(mem_chipselect), 32'd1);
    check("wr_cmd_we", 32'(mem_write), 32'd1);
    check("wr_cmd_addr", 32'(mem_address), 32'(exp_addr));
    check("wr_cmd_data", mem_writedata, data);
    check("wr_cmd_be", 32'(mem_byteenable), 32'hF);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       exp_data;
    logic              exp_err;
  } rd_vec_t;

  rd_vec_t rd_tab [8];

  initial begin
    int n;
    int seen;
    logic found;

    // Memory contents expected after DEPTH+2 samples numbered 0,1,2,...
    rd_tab[0] = '{addr: 15'd0,     exp_data: 32'd25000, exp_err: 1'b0};
    rd_tab[1] = '{addr: 15'd1,     exp_data: 32'd25001, exp_err: 1'b0};
    rd_tab[2] = '{addr: 15'd2,     exp_data: 32'd2,     exp_err: 1'b0};
    rd_tab[3] = '{addr: 15'd3,     exp_data: 32'd3,     exp_err: 1'b0};
    rd_tab[4] = '{addr: 15'd24998, exp_data: 32'd24998, exp_err: 1'b0};
    rd_tab[5] = '{addr: 15'd24999, exp_data: 32'd24999, exp_err: 1'b0};
    rd_tab[6] = '{addr: 15'd25000, exp_data: 32'd0,     exp_err: 1'b1};
    rd_tab[7] = '{addr: 15'd32767, exp_data: 32'd0,     exp_err: 1'b1};

    reset_n   = 1'b0;
    enable    = 1'b0;
    clear     = 1'b0;
    snk_valid = 1'b0;
    snk_data  = 32'h0;
    rd_req    = 1'b0;
    rd_addr   = '0;

    // ---- reset values ----
    tick(3);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    check("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    check("rst_fill", 32'(fill_count), 32'd0);
    check("rst_wrapped", 32'(wrapped), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_err", 32'(rd_err), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_mem_cs", 32'(mem_chipselect), 32'd0);
    check("rst_mem_we", 32'(mem_write), 32'd0);
    check("rst_mem_clken", 32'(mem_clken), 32'd0);
    check("rst_mem_addr", 32'(mem_address), 32'd0);
    check("rst_mem_be", 32'(mem_byteenable), 32'd0);
    check("rst_mem_wdata", mem_writedata, 32'd0);

    reset_n = 1'b1;
    #1;
    check("clken_after_reset", 32'(mem_clken), 32'd1);
    tick(1);
    check("idle_snk_ready", 32'(snk_ready), 32'd0);

    // ---- basic logging: A1, A2, A3 to addresses 0..2 ----
    enable = 1'b1;
    tick(1);
    check("run_state", 32'(fsm_state), 32'(ST_RUN));
    send_sample(32'hA1, 0);
    send_sample(32'hA2, 1);
    send_sample(32'hA3, 2);
    check("wr_ptr_3", 32'(wr_ptr), 32'd3);
    check("fill_3", 32'(fill_count), 32'd3);
    tick(1);
    check("idle_cycle_cs", 32'(mem_chipselect), 32'd0);
    check("idle_cycle_we", 32'(mem_write), 32'd0);

    // ---- read wins over a pending sample ----
    snk_valid = 1'b1;
    snk_data  = 32'hB0;
    rd_req    = 1'b1;
    rd_addr   = 15'd1;
    #1;
    check("prio_snk_ready", 32'(snk_ready), 32'd0);
    check("prio_rd_ack", 32'(rd_ack), 32'd1);
    push_read(32'hA2, 1'b0);
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    check("prio_blocked_ptr", 32'(wr_ptr), 32'd3);
    check("prio_rd_cmd", 32'({mem_chipselect, mem_write}), 32'b10);
    #1;
    check("prio_ready_back", 32'(snk_ready), 32'd1);
    @(posedge clk);
    #1;
    snk_valid = 1'b0;
    check("prio_wr_addr", 32'(mem_address), 32'd3);
    check("prio_wr_data", mem_writedata, 32'hB0);
    check("prio_wr_ptr", 32'(wr_ptr), 32'd4);

    // ---- out-of-range read and back-to-back pipelining ----
    do_read(15'd25000, 32'd0, 1'b1);
    do_read(15'd0, 32'hA1, 1'b0);
    do_read(15'd3, 32'hB0, 1'b0);
    tick(5);
    check("rd_queue_drained_1", 32'(exp_q.size()), 32'd0);

    // ---- scrub, restarted by a second clear at address 100 ----
    scrub_watch    = 1'b1;
    scrub_exp_addr = 0;
    clear          = 1'b1;
    rd_req         = 1'b1;
    rd_addr        = 15'd0;
    #1;
    check("clear_blocks_rd_ack", 32'(rd_ack), 32'd0);
    rd_req = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("scrub_state", 32'(fsm_state), 32'(ST_SCRUB));
    check("scrub_busy", 32'(busy), 32'd1);
    check("scrub_first_idle", 32'(mem_chipselect), 32'd0);
    found = 1'b0;
    for (int k = 0; k < 500 && !found; k++) begin
      @(posedge clk);
      #1;
      if (mem_chipselect && mem_write && mem_address == 15'd100) found = 1'b1;
    end
    check("scrub_reached_100", 32'(found), 32'd1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear          = 1'b0;
    scrub_exp_addr = 0;
    check("restart_idle_cs", 32'(mem_chipselect), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 30000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("scrub_busy_cycles", 32'(n), 32'd25000);
    @(negedge clk);
    #1;
    scrub_watch = 1'b0;
    check("scrub_write_count", 32'(scrub_exp_addr), 32'd25000);
    check("post_scrub_wr_ptr", 32'(wr_ptr), 32'd0);
    check("post_scrub_fill", 32'(fill_count), 32'd0);
    check("post_scrub_wrapped", 32'(wrapped), 32'd0);
    check("post_scrub_state", 32'(fsm_state), 32'(ST_RUN));
    @(posedge clk);
    #1;

    // ---- DEPTH+2 samples: wrap after 24999 ----
    for (int i = 0; i < DEPTH + 2; i++) begin
      send_sample(32'(i), (i < DEPTH) ? i : i - DEPTH);
      if (i == DEPTH - 2) check("wrapped_before", 32'(wrapped), 32'd0);
      if (i == DEPTH - 1) begin
        check("wrapped_at", 32'(wrapped), 32'd1);
        check("wr_ptr_at_wrap", 32'(wr_ptr), 32'd0);
        check("fill_full", 32'(fill_count), 32'd25000);
      end
    end
    check("wrap_wr_ptr", 32'(wr_ptr), 32'd2);
    check("wrap_flag", 32'(wrapped), 32'd1);
    check("wrap_fill_sat", 32'(fill_count), 32'd25000);

    // ---- table-driven readback, issued back to back ----
    for (int v = 0; v < 8; v++) begin
      do_read(rd_tab[v].addr, rd_tab[v].exp_data, rd_tab[v].exp_err);
    end
    tick(6);
    check("rd_queue_drained_2", 32'(exp_q.size()), 32'd0);

    // ---- read accepted just before scrub entry still completes ----
    do_read(15'd10, 32'd10, 1'b0);
    scrub_watch    = 1'b1;
    scrub_exp_addr = 0;
    clear          = 1'b1;
    @(posedge clk);
    #1;
    clear  = 1'b0;
    rd_req = 1'b1;
    #1;
    check("scrub_rd_ack", 32'(rd_ack), 32'd0);
    check("scrub_snk_ready", 32'(snk_ready), 32'd0);
    rd_req = 1'b0;
    tick(20);
    check("rd_queue_drained_3", 32'(exp_q.size()), 32'd0);

    // ---- reset in the middle of the scrub ----
    scrub_watch = 1'b0;
    reset_n     = 1'b0;
    #1;
    check("midscrub_busy", 32'(busy), 32'd0);
    check("midscrub_state", 32'(fsm_state), 32'(ST_IDLE));
    check("midscrub_cs", 32'(mem_chipselect), 32'd0);
    check("midscrub_we", 32'(mem_write), 32'd0);
    check("midscrub_clken", 32'(mem_clken), 32'd0);
    check("midscrub_wr_ptr", 32'(wr_ptr), 32'd0);
    check("midscrub_fill", 32'(fill_count), 32'd0);
    check("midscrub_wrapped", 32'(wrapped), 32'd0);
    tick(2);
    reset_n = 1'b1;
    #1;
    check("release_state", 32'(fsm_state), 32'(ST_IDLE));
    check("release_busy", 32'(busy), 32'd0);
    tick(2);
    check("release_run", 32'(fsm_state), 32'(ST_RUN));

    // ---- reset with a read in flight: no response may appear ----
    do_read(15'd2, 32'd2, 1'b0);
    reset_n = 1'b0;
    exp_q.delete();
    exp_err_q.delete();
    exp_cyc_q.delete();
    tick(2);
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rd_valid) seen++;
    end
    check("aborted_read_silent", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
